// File: rtl/data_array_refill_ctrl.sv
// Two-beat row refill into a 128-bit data array, plus a registered read path.
// Optional range checking: define DATA_ARRAY_ADDR_CHECK_EN.
module data_array_refill_ctrl #(
  parameter int ROWS = 40,
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          refill_valid,
  output logic          refill_ready,
  input  logic [AW-1:0] refill_addr,
  input  logic [63:0]   refill_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_resp_valid,
  output logic [127:0]  rd_resp_data,
  output logic [AW-1:0] arr_R0_addr,
  output logic          arr_R0_en,
  output logic [AW-1:0] arr_W0_addr,
  output logic          arr_W0_en,
  output logic [127:0]  arr_W0_data,
  input  logic [127:0]  arr_R0_data,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    HALF,
    WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q;
  logic [63:0]   lo_q, hi_q;
  logic          beat_acc, rd_acc, hazard;
  logic          rd_oob, row_bad_q;

  assign refill_ready = !reset && (state_q != WRITE);
  assign beat_acc = refill_valid && refill_ready;

  // A row being assembled must not be read until it has landed.
  assign hazard = (state_q != IDLE) && (rd_req_addr == row_q);
  assign rd_req_ready = !reset && !hazard;
  assign rd_acc = rd_req_valid && rd_req_ready;

`ifdef DATA_ARRAY_ADDR_CHECK_EN
  logic wr_oob, err_q;

  assign rd_oob = {1'b0, rd_req_addr} >= (AW+1)'(ROWS);
  assign wr_oob = {1'b0, refill_addr} >= (AW+1)'(ROWS);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q     <= 1'b0;
      row_bad_q <= 1'b0;
    end else begin
      if (beat_acc && state_q == IDLE)
        row_bad_q <= wr_oob;
      if ((rd_acc && rd_oob) ||
          (beat_acc && state_q == IDLE && wr_oob))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_rows;

  assign unused_rows = (ROWS > 0);
  assign rd_oob = 1'b0;
  assign row_bad_q = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat_acc) state_d = HALF;
      HALF:    if (beat_acc) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else if (beat_acc) begin
      if (state_q == IDLE) begin
        row_q <= refill_addr;
        lo_q  <= refill_data;
      end else begin
        hi_q  <= refill_data;
      end
    end
  end

  assign arr_W0_en   = !reset && (state_q == WRITE) && !row_bad_q;
  assign arr_W0_addr = row_q;
  assign arr_W0_data = {hi_q, lo_q};

  assign arr_R0_en   = rd_acc && !rd_oob;
  assign arr_R0_addr = rd_req_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      rd_resp_valid <= rd_acc;
      if (rd_acc)
        rd_resp_data <= rd_oob ? '0 : arr_R0_data;
    end
  end

endmodule

// File: tb/tb_data_array_refill_ctrl.sv
// Bench for data_array_refill_ctrl: behavioural array + transaction model,
// directed scenarios and a randomized run.
module tb_data_array_refill_ctrl;

  localparam int ROWS = 40;
  localparam int AW = 6;
`ifdef DATA_ARRAY_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          refill_valid;
  logic          refill_ready;
  logic [AW-1:0] refill_addr;
  logic [63:0]   refill_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid;
  logic [127:0]  rd_resp_data;
  logic [AW-1:0] arr_R0_addr;
  logic          arr_R0_en;
  logic [AW-1:0] arr_W0_addr;
  logic          arr_W0_en;
  logic [127:0]  arr_W0_data;
  logic [127:0]  arr_R0_data;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  data_array_refill_ctrl #(.ROWS(ROWS), .AW(AW)) dut (
    .clock        (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill_ready (refill_ready),
    .refill_addr  (refill_addr),
    .refill_data  (refill_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .arr_R0_addr  (arr_R0_addr),
    .arr_R0_en    (arr_R0_en),
    .arr_W0_addr  (arr_W0_addr),
    .arr_W0_en    (arr_W0_en),
    .arr_W0_data  (arr_W0_data),
    .arr_R0_data  (arr_R0_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] init_val(int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The attached array: combinational read, write at the clock edge.
  logic [127:0] mem [64];
  logic         mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (arr_W0_en) begin
      mem[arr_W0_addr] <= arr_W0_data;
    end
  end

  assign arr_R0_data = arr_R0_en ? mem[arr_R0_addr] : 128'h0;

  // Reference: what the array should hold and what each cycle must show.
  logic [127:0] gold [64];
  logic         g_init = 1'b0;
  int           beats_taken = 0;
  logic [AW-1:0] m_row = '0;
  logic [63:0]  m_lo = '0, m_hi = '0;
  logic         m_bad = 1'b0;
  logic         m_rv = 1'b0;
  logic [127:0] m_rd = '0;
  logic         m_err = 1'b0;

  always @(negedge clk) begin
    logic e_rr, e_qr, rd_acc, oob_r, e_r0, e_w0, acc;
    if (!g_init) begin
      for (int i = 0; i < 64; i++) gold[i] = init_val(i);
      g_init = 1'b1;
    end
    e_rr   = !reset && beats_taken != 2;
    e_qr   = !reset && !(beats_taken != 0 && rd_req_addr == m_row);
    rd_acc = rd_req_valid && e_qr;
    oob_r  = CHK && (int'(rd_req_addr) >= ROWS);
    e_r0   = rd_acc && !oob_r;
    e_w0   = !reset && beats_taken == 2 && !m_bad;

    chk("refill_ready", 128'(refill_ready), 128'(e_rr));
    chk("rd_req_ready", 128'(rd_req_ready), 128'(e_qr));
    chk("arr_R0_en", 128'(arr_R0_en), 128'(e_r0));
    if (e_r0) chk("arr_R0_addr", 128'(arr_R0_addr), 128'(rd_req_addr));
    chk("arr_W0_en", 128'(arr_W0_en), 128'(e_w0));
    if (e_w0) begin
      chk("arr_W0_addr", 128'(arr_W0_addr), 128'(m_row));
      chk("arr_W0_data", arr_W0_data, {m_hi, m_lo});
    end
    chk("rd_resp_valid", 128'(rd_resp_valid), 128'(m_rv));
    chk("rd_resp_data", rd_resp_data, m_rd);
    chk("err", 128'(err), 128'(m_err));

    if (reset) begin
      beats_taken = 0;
      m_bad = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
      m_err = 1'b0;
    end else begin
      m_rv = rd_acc;
      if (rd_acc) m_rd = oob_r ? 128'h0 : gold[rd_req_addr];
      if (rd_acc && oob_r) m_err = 1'b1;
      if (e_w0) gold[m_row] = {m_hi, m_lo};
      acc = refill_valid && e_rr;
      if (beats_taken == 2) begin
        beats_taken = 0;
      end else if (acc && beats_taken == 0) begin
        m_row = refill_addr;
        m_lo  = refill_data;
        m_bad = CHK && (int'(refill_addr) >= ROWS);
        if (m_bad) m_err = 1'b1;
        beats_taken = 1;
      end else if (acc) begin
        m_hi = refill_data;
        beats_taken = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    reset = 1'b1;
    refill_valid = 1'b0;
    refill_addr = '0;
    refill_data = '0;
    rd_req_valid = 1'b0;
    rd_req_addr = '0;
    tick();
    tick();
    chk("reset_resp_valid", 128'(rd_resp_valid), 128'h0);
    chk("reset_resp_data", rd_resp_data, 128'h0);
    chk("reset_refill_ready", 128'(refill_ready), 128'h0);
    reset = 1'b0;

    // Row 5 refill then read back.
    refill_valid = 1'b1; refill_addr = 6'd5; refill_data = 64'hA;
    tick();
    refill_addr = 6'd0; refill_data = 64'hB;
    tick();
    refill_valid = 1'b0;
    #1;
    chk("w5_en", 128'(arr_W0_en), 128'h1);
    chk("w5_addr", 128'(arr_W0_addr), 128'd5);
    chk("w5_data", arr_W0_data, {64'hB, 64'hA});
    chk("w5_ready", 128'(refill_ready), 128'h0);
    tick();
    rd_req_valid = 1'b1; rd_req_addr = 6'd5;
    tick();
    rd_req_valid = 1'b0;
    chk("r5_valid", 128'(rd_resp_valid), 128'h1);
    chk("r5_data", rd_resp_data, {64'hB, 64'hA});
    tick();
    chk("r5_drop", 128'(rd_resp_valid), 128'h0);
    chk("r5_hold", rd_resp_data, {64'hB, 64'hA});

    // Read of row 7 stalls while row 7 is partially written.
    refill_valid = 1'b1; refill_addr = 6'd7; refill_data = 64'hC;
    tick();
    refill_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 6'd7;
    #1;
    chk("h7_half", 128'(rd_req_ready), 128'h0);
    tick();
    refill_valid = 1'b1; refill_data = 64'hD;
    tick();
    refill_valid = 1'b0;
    #1;
    chk("h7_write", 128'(rd_req_ready), 128'h0);
    tick();
    chk("h7_idle", 128'(rd_req_ready), 128'h1);
    tick();
    rd_req_valid = 1'b0;
    chk("h7_data", rd_resp_data, {64'hD, 64'hC});

    // Reads of rows 0,1,2 overlapping a refill of row 9.
    refill_valid = 1'b1; refill_addr = 6'd9; refill_data = 64'h1;
    rd_req_valid = 1'b1; rd_req_addr = 6'd0;
    tick();
    refill_data = 64'h2; rd_req_addr = 6'd1;
    chk("p0", rd_resp_data, init_val(0));
    tick();
    refill_valid = 1'b0; rd_req_addr = 6'd2;
    chk("p1", rd_resp_data, init_val(1));
    #1;
    chk("p9_w", arr_W0_data, {64'h2, 64'h1});
    tick();
    rd_req_valid = 1'b0;
    chk("p2", rd_resp_data, init_val(2));

    // Reset in the middle of a row 3 refill.
    refill_valid = 1'b1; refill_addr = 6'd3; refill_data = 64'hE;
    tick();
    refill_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst_rd_ready", 128'(rd_req_ready), 128'h0);
    tick();
    reset = 1'b0;
    tick();
    rd_req_valid = 1'b1; rd_req_addr = 6'd3;
    tick();
    rd_req_valid = 1'b0;
    chk("r3_untouched", rd_resp_data, init_val(3));
    refill_valid = 1'b1; refill_data = 64'hF;
    tick();
    refill_data = 64'h10;
    tick();
    refill_valid = 1'b0;
    tick();
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("r3_new", rd_resp_data, {64'h10, 64'hF});

`ifdef DATA_ARRAY_ADDR_CHECK_EN
    rd_req_valid = 1'b1; rd_req_addr = 6'd45;
    #1;
    chk("oob_r0_en", 128'(arr_R0_en), 128'h0);
    tick();
    rd_req_valid = 1'b0;
    chk("oob_valid", 128'(rd_resp_valid), 128'h1);
    chk("oob_data", rd_resp_data, 128'h0);
    chk("oob_err", 128'(err), 128'h1);
    refill_valid = 1'b1; refill_addr = 6'd40; refill_data = 64'h5;
    #1;
    chk("oob_b0", 128'(refill_ready), 128'h1);
    tick();
    #1;
    chk("oob_b1", 128'(refill_ready), 128'h1);
    tick();
    refill_valid = 1'b0;
    #1;
    chk("oob_w0", 128'(arr_W0_en), 128'h0);
    tick();
    tick();
    chk("oob_sticky", 128'(err), 128'h1);
`endif

    // Randomized traffic; a stalled refill beat is held unchanged.
    acc = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (!refill_valid || acc) begin
        refill_valid = ($urandom_range(0, 9) < 6);
        refill_addr = ($urandom_range(0, 3) == 0) ?
                      6'($urandom_range(0, 63)) :
                      6'($urandom_range(0, 11));
        refill_data = {$urandom, $urandom};
      end
      rd_req_valid = ($urandom_range(0, 9) < 7);
      rd_req_addr = ($urandom_range(0, 3) == 0) ?
                    6'($urandom_range(0, 63)) :
                    6'($urandom_range(0, 11));
      reset = ($urandom_range(0, 249) == 0);
      #1;
      acc = refill_valid && refill_ready;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    refill_valid = 1'b0;
    rd_req_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_array_refill_ctrl.md
DATA_ARRAY_REFILL_CTRL -- requirements
Module: data_array_refill_ctrl

Interface
REQ-001 Parameter ROWS, default 40: number of rows in the attached data array; legal addresses are 0..ROWS-1.
REQ-002 Parameter AW, default 6: address width.
REQ-003 clock  input  1  single clock for all state; the array's R0_clk and W0_clk are tied to it externally.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 refill_valid  input  1  refill beat valid.
REQ-006 refill_ready  output  1  refill beat accepted when valid and ready are both high.
REQ-007 refill_addr  input  AW  target row; sampled on the first beat only.
REQ-008 refill_data  input  64  beat payload: first beat is bits 63:0, second beat is bits 127:64.
REQ-009 rd_req_valid / rd_req_ready / rd_req_addr  input/output/input  1/1/AW  read request handshake.
REQ-010 rd_resp_valid / rd_resp_data  output  1/128  registered read response; the consumer cannot apply backpressure.
REQ-011 arr_R0_addr, arr_R0_en, arr_W0_addr, arr_W0_en, arr_W0_data  output  AW/1/AW/1/128  drive the array ports.
REQ-012 arr_R0_data  input  128  array read data, combinational from arr_R0_addr/arr_R0_en.
REQ-013 err  output  1  sticky address-range error flag.

Function
REQ-014 The refill FSM SHALL have three states: IDLE, HALF and WRITE.
- IDLE -> HALF on an accepted beat; the beat captures the low half and the row address.
- HALF -> WRITE on an accepted beat; the beat captures the high half.
- WRITE -> IDLE unconditionally after one cycle.
REQ-015 refill_ready SHALL be 1 in IDLE and HALF and 0 in WRITE.
REQ-016 In WRITE, arr_W0_en SHALL be 1, with arr_W0_addr equal to the captured row and arr_W0_data equal to {high, low}; in all other states arr_W0_en SHALL be 0.
REQ-017 Refill throughput SHALL be at most one row per 3 cycles; beats arriving while refill_ready=0 SHALL be held by the producer and not lost.
REQ-018 rd_req_ready SHALL be 0 when the FSM is in HALF or WRITE and rd_req_addr equals the captured row (read-after-partial-write hazard); otherwise rd_req_ready SHALL be 1.
REQ-019 For an accepted read in cycle N: arr_R0_en=1 and arr_R0_addr=rd_req_addr in cycle N; arr_R0_data is registered at the end of cycle N; rd_resp_valid=1 with that data for exactly cycle N+1.
REQ-020 When no read is accepted, arr_R0_en SHALL be 0 and rd_resp_valid SHALL be 0 in the following cycle; rd_resp_data SHALL hold its last value.
REQ-021 A read and a row write to different addresses in the same cycle SHALL both proceed; a back-to-back read every cycle SHALL be sustained.
REQ-022 The second beat's refill_addr SHALL be ignored.

Reset
REQ-023 On reset, the FSM SHALL return to IDLE, and rd_resp_valid=0, rd_resp_data=0, err=0, arr_W0_en=0 and arr_R0_en=0.
REQ-024 A reset asserted in HALF or WRITE SHALL discard the partial row; no array write SHALL occur in or after the reset cycle.
REQ-025 refill_ready and rd_req_ready SHALL be 0 while reset is high.

Configuration
REQ-026 Macro DATA_ARRAY_ADDR_CHECK_EN, when defined:
- A read with rd_req_addr >= ROWS SHALL be accepted, SHALL NOT drive arr_R0_en, SHALL return rd_resp_valid=1 with data 0, and SHALL set err.
- A refill whose first-beat address is >= ROWS SHALL consume both beats, SHALL suppress arr_W0_en in WRITE, and SHALL set err.
REQ-027 When the macro is not defined, err SHALL be tied to 0 and out-of-range addresses SHALL pass to the array unchecked.

Verification
REQ-028 Reset, then refill row 5 with beats 64'hA / 64'hB -> in cycle 3, arr_W0_en=1, arr_W0_addr=5, arr_W0_data={64'hB,64'hA}; then read row 5 -> rd_resp_data={B,A} one cycle later.
REQ-029 After the first beat to row 7, hold rd_req_valid=1 with addr 7 -> rd_req_ready=0 until the cycle after WRITE, then the response returns the new row.
REQ-030 Read requests to addrs 0,1,2 in consecutive cycles while a refill to row 9 runs -> three responses in consecutive cycles; the write to row 9 is unaffected.
REQ-031 Assert reset while in HALF for row 3 -> no write to row 3 ever; a subsequent refill to row 3 writes only the new data.
REQ-032 With DATA_ARRAY_ADDR_CHECK_EN defined, read addr 45 -> rd_resp_valid=1, data 0, err=1 sticky until reset, arr_R0_en never 1; refill to addr 40 -> both beats accepted, no arr_W0_en.
